// File: rtl/moore_seq_tx.sv
// moore_seq_tx: LSB-first serial transmitter with Moore-decoded out/busy/done.
// Define MOORE_SEQ_TX_PARITY_EN to append an even-parity bit after the data bits.
module moore_seq_tx #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             out,
    output logic             busy,
    output logic             done
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef MOORE_SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_SHIFT = 2'b01, S_PARITY = 2'b10, S_DONE = 2'b11} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_SHIFT = 2'b01, S_DONE = 2'b11} state_t;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             w_load;
    logic             w_last;
`ifdef MOORE_SEQ_TX_PARITY_EN
    logic             r_par;
`endif

    assign w_load = (r_state == S_IDLE) && start;
    assign w_last = r_cnt == LAST;

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = start ? S_SHIFT : S_IDLE;
`ifdef MOORE_SEQ_TX_PARITY_EN
            S_SHIFT:  w_next = w_last ? S_PARITY : S_SHIFT;
            S_PARITY: w_next = S_DONE;
`else
            S_SHIFT:  w_next = w_last ? S_DONE : S_SHIFT;
`endif
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_sr  <= data;
                r_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_sr  <= r_sr >> 1;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef MOORE_SEQ_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_par <= 1'b0;
        else if (w_load)
            r_par <= ^data;
    end
`endif

    // Outputs depend on registers only, so downstream logic sees no path from start/data.
    always_comb begin
        busy = r_state == S_SHIFT;
        done = r_state == S_DONE;
        out  = (r_state == S_SHIFT) ? r_sr[0] : IDLE_LEVEL;
`ifdef MOORE_SEQ_TX_PARITY_EN
        busy = busy || (r_state == S_PARITY);
        out  = (r_state == S_PARITY) ? r_par : out;
`endif
    end
endmodule

// File: tb/tb_moore_seq_tx.sv
// tb_moore_seq_tx: directed and random frames checked against a frame-queue model.
module tb_moore_seq_tx;
    localparam int W = 8;

    typedef struct packed {
        logic [1:0] k;
        logic       b;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data = '0;
    logic         out1, busy1, done1;
    logic         out0, busy0, done0;
    ent_t         q[$];
    int           vec = 0;
    int           mis = 0;

    always #5 clk = ~clk;

    moore_seq_tx #(.WIDTH(W), .IDLE_LEVEL(1'b1)) u_hi (
        .clk(clk), .reset(reset), .start(start), .data(data),
        .out(out1), .busy(busy1), .done(done1)
    );

    moore_seq_tx #(.WIDTH(W), .IDLE_LEVEL(1'b0)) u_lo (
        .clk(clk), .reset(reset), .start(start), .data(data),
        .out(out0), .busy(busy0), .done(done0)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    // Queue entry kinds: 1 = data/parity bit on the line, 2 = completion cycle; empty queue = idle.
    task automatic check_all();
        ent_t e;
        e = (q.size() != 0) ? q[0] : ent_t'(3'b000);
        chk("out_idle1", out1, (e.k == 2'd1) ? e.b : 1'b1);
        chk("out_idle0", out0, (e.k == 2'd1) ? e.b : 1'b0);
        chk("busy_idle1", busy1, e.k == 2'd1);
        chk("busy_idle0", busy0, e.k == 2'd1);
        chk("done_idle1", done1, e.k == 2'd2);
        chk("done_idle0", done0, e.k == 2'd2);
    endtask

    task automatic push_frame(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) q.push_back(ent_t'({2'd1, d[i]}));
`ifdef MOORE_SEQ_TX_PARITY_EN
        q.push_back(ent_t'({2'd1, ^d}));
`endif
        q.push_back(ent_t'({2'd2, 1'b0}));
    endtask

    task automatic step(input logic s, input logic [W-1:0] d);
        start = s;
        data  = d;
        @(posedge clk);
        if (reset)
            q.delete();
        else if (q.size() != 0)
            void'(q.pop_front());
        else if (s)
            push_frame(d);
        #1 check_all();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1 q.delete();
        check_all();
    endtask

    initial begin
        #1 check_all();
        repeat (2) step(1'b1, 8'hA5);
        reset = 1'b0;
        repeat (2) step(1'b0, 8'h00);

        step(1'b1, 8'hA5);
        repeat (11) step(1'b0, 8'h3C);

        step(1'b1, 8'hA5);
        repeat (3) step(1'b1, 8'hFF);
        repeat (4) step(1'b0, 8'hFF);
        repeat (3) step(1'b1, 8'hFF);
        repeat (6) step(1'b0, 8'hFF);

        repeat (35) step(1'b1, 8'h01);
        repeat (12) step(1'b0, 8'h00);

        step(1'b1, 8'h5A);
        repeat (3) step(1'b0, 8'h00);
        async_reset();
        repeat (3) step(1'b1, 8'hFF);
        reset = 1'b0;
        #1 check_all();
        step(1'b1, 8'hC3);
        repeat (12) step(1'b0, 8'h00);

        step(1'b1, 8'hFF);
        repeat (12) step(1'b0, 8'h00);
        step(1'b1, 8'h07);
        repeat (12) step(1'b0, 8'h00);
        step(1'b1, 8'h80);
        repeat (12) step(1'b0, 8'h00);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, W'($urandom));
            if (i == 200) begin
                async_reset();
                step(1'b1, W'($urandom));
                reset = 1'b0;
            end
        end
        repeat (12) step(1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
